// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills/write-backs.
// Round-robin on ties, fixed-length bursts with per-beat addressing and a done pulse.
module mem_port_arbiter #(
    parameter int LINE_WORDS = 4,
    localparam int BEAT_W = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [31:0]       ic_addr,
    output logic              ic_grant,
    output logic [31:0]       ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [31:0]       dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic              dc_grant,
    output logic [BEAT_W-1:0] dc_beat,
    output logic [31:0]       dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);
    localparam int OFF_W = BEAT_W + 2;
    localparam logic [31:0] OFF_MASK = 32'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state, state_nxt;
    logic              owner;       // 1 = D-cache
    logic              last_owner;  // starts at I so D wins the first tie
    logic              we_lat;
    logic [31:0]       base;
    logic [BEAT_W-1:0] beat;
    logic              any_req, pick_d, last_beat;
    logic              busy, rd_beat;

    assign any_req   = ic_req | dc_req;
    assign pick_d    = dc_req & (~ic_req | ~last_owner);
    assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b0;
            we_lat     <= 1'b0;
            base       <= '0;
            beat       <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner  <= pick_d;
                    we_lat <= pick_d & dc_we;
                    base   <= (pick_d ? dc_addr : ic_addr) & ~OFF_MASK;
                    beat   <= '0;
                end
                // beat wraps to 0 on the last beat since LINE_WORDS is a power of 2
                BURST: if (mem_ready) beat <= beat + BEAT_W'(1);
                DONE:  last_owner <= owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BURST;
            BURST:   if (mem_ready && last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_beat   = 1'b0;
        if (state == BURST) begin
            mem_req   = 1'b1;
            mem_we    = we_lat;
            mem_addr  = base + (32'(beat) << 2);
            mem_wdata = (owner && we_lat) ? dc_wdata : '0;
            rd_beat   = mem_ready & ~we_lat;
        end
        ic_grant  = busy & ~owner;
        dc_grant  = busy & owner;
        ic_done   = (state == DONE) & ~owner;
        dc_done   = (state == DONE) & owner;
        ic_rvalid = rd_beat & ~owner;
        dc_rvalid = rd_beat & owner;
        ic_rdata  = ic_rvalid ? mem_rdata : '0;
        dc_rdata  = dc_rvalid ? mem_rdata : '0;
        dc_beat   = (state == BURST && owner) ? beat : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected beats are queued per burst and
// popped as the memory side completes each beat.
module tb_mem_port_arbiter;
    localparam int LW = 4;
    localparam int BW = $clog2(LW);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ic_req, dc_req, dc_we, mem_ready;
    logic [31:0]   ic_addr, dc_addr, dc_wdata, mem_rdata;
    logic          ic_grant, ic_rvalid, ic_done, dc_grant, dc_rvalid, dc_done;
    logic          mem_req, mem_we;
    logic [31:0]   ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic [BW-1:0] dc_beat;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rbase;
    int          nbeats;

    mem_port_arbiter #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant), .ic_rdata(ic_rdata),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_grant(dc_grant), .dc_beat(dc_beat), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
        .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // memory returns rbase + beat count; D-cache supplies 0x100 + beat index
    assign mem_rdata = rbase + 32'(nbeats);
    assign dc_wdata  = 32'h100 + 32'(dc_beat);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered at an IDLE cycle with the request already driven; returns in the
    // IDLE cycle after done, before the edge that samples the next request.
    task automatic burst(input bit own_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] rb, input int stall_at, input int stall_n,
                         input bit drop);
        logic [31:0] base;
        int          stalls = 0;
        int          cyc = 0;
        bit          done_seen = 0;
        beat_t       e;
        base   = addr & ~32'(LW * 4 - 1);
        rbase  = rb;
        nbeats = 0;
        for (int k = 0; k < LW; k++)
            exp_q.push_back('{base + 32'(4 * k), we, we ? 32'h100 + 32'(k) : 32'h0, rb + 32'(k)});
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ready = !(stall_at >= 0 && nbeats == stall_at + 1 && stalls < stall_n);
            if (!mem_ready) stalls++;
            #1;
            chk("own_grant", 32'(own_d ? dc_grant : ic_grant), 1);
            chk("other_grant", 32'(own_d ? ic_grant : dc_grant), 0);
            chk("other_done_rvalid", 32'(own_d ? {ic_done, ic_rvalid} : {dc_done, dc_rvalid}), 0);
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_wdata", mem_wdata, e.wdata);
                    chk("dc_beat", 32'(dc_beat), own_d ? 32'(nbeats) : 0);
                    chk("own_rvalid", 32'(own_d ? dc_rvalid : ic_rvalid), 32'(mem_ready & ~we));
                    if (mem_ready) begin
                        if (!we) chk("own_rdata", own_d ? dc_rdata : ic_rdata, e.rdata);
                        void'(exp_q.pop_front());
                        nbeats++;
                        if (drop && nbeats == 1) dc_req = 1'b0;
                    end
                end
            end else begin
                chk("own_done", 32'(own_d ? dc_done : ic_done), 1);
                chk("beats_at_done", nbeats, LW);
                chk("done_cycle", cyc, LW + stall_n + 1);
                done_seen = 1;
            end
        end
        if (!done_seen) chk("burst_timeout", 0, 1);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("idle_after_done", 32'({ic_grant, dc_grant, ic_done, dc_done, mem_req}), 0);
    endtask

    initial begin
        rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; mem_ready = 1'b1; rbase = '0; nbeats = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", 32'({ic_grant, dc_grant, ic_rvalid, ic_done, dc_rvalid, dc_done, mem_req, mem_we}), 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_data", ic_rdata | dc_rdata | mem_wdata | 32'(dc_beat), 0);

        // both requesting from reset: D, I, D, I
        rst_n = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
        ic_addr = 32'h0000_3008; dc_addr = 32'h0000_4014;
        burst(1, 0, dc_addr, 32'hD0, -1, 0, 0);
        burst(0, 0, ic_addr, 32'hB0, -1, 0, 0);
        burst(1, 0, dc_addr, 32'hD4, -1, 0, 0);
        burst(0, 0, ic_addr, 32'hB4, -1, 0, 0);
        ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk); #1;
        chk("no_grant_after_release", 32'({ic_grant, dc_grant}), 0);

        // I-cache refill
        ic_req = 1'b1; ic_addr = 32'h0000_104C;
        burst(0, 0, ic_addr, 32'hA0, -1, 0, 0);
        ic_req = 1'b0;

        // D-cache write-back
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_2004;
        burst(1, 1, dc_addr, 32'h0, -1, 0, 0);
        dc_req = 1'b0;

        // D refill with 3-cycle memory stall after beat 1
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_5028;
        burst(1, 0, dc_addr, 32'hC0, 1, 3, 0);
        dc_req = 1'b0;

        // D refill with request dropped after beat 0
        @(negedge clk);
        dc_req = 1'b1; dc_addr = 32'hFFFF_FFF0;
        burst(1, 0, dc_addr, 32'hE0, -1, 0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("no_regrant_after_drop", 32'({ic_grant, dc_grant, mem_req}), 0);
        end

        // reset during beat 2 of an I refill
        ic_req = 1'b1; ic_addr = 32'h0000_7000; rbase = 32'hF0; nbeats = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("pre_reset_addr", mem_addr, 32'h0000_7000 + 32'(4 * c));
            nbeats++;
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_ctrl", 32'({ic_grant, dc_grant, ic_rvalid, ic_done, dc_rvalid, dc_done, mem_req, mem_we}), 0);
        chk("midrst_addr", mem_addr, 0);
        rst_n = 1'b1;
        burst(0, 0, ic_addr, 32'hF0, -1, 0, 0);
        ic_req = 1'b0;

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between I-cache line refills and D-cache line refills/write-backs.
- Sits between the two cache controllers and the external memory model. The D-cache side feeds the MEM-stage stall path, so its latency bounds MEM stalls.
- Grants one requester at a time, sequences a fixed-length word burst with per-beat addressing, and signals completion.

Parameters:
- LINE_WORDS, 4: words per cache line (burst length); power of 2, range 2..16.
- BEAT_W, $clog2(LINE_WORDS): beat index width (localparam, derived).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- ic_req  in  1  I-cache line-read request; held until ic_done
- ic_addr  in  32  I-cache miss address (any byte in line)
- ic_grant  out  1  I-cache owns memory port
- ic_rdata  out  32  refill word
- ic_rvalid  out  1  ic_rdata valid this cycle
- ic_done  out  1  one-cycle pulse, burst complete
- dc_req  in  1  D-cache request; held until dc_done
- dc_we  in  1  1 = write-back line, 0 = refill; sampled at grant
- dc_addr  in  32  D-cache line address
- dc_wdata  in  32  write-back word for current dc_beat
- dc_grant  out  1  D-cache owns memory port
- dc_beat  out  BEAT_W  current beat index (D-cache selects wdata)
- dc_rdata  out  32  refill word
- dc_rvalid  out  1  dc_rdata valid this cycle
- dc_done  out  1  one-cycle pulse, burst complete
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  32  word address of current beat
- mem_wdata  out  32  write data of current beat
- mem_rdata  in  32  read data, valid when mem_ready
- mem_ready  in  1  memory completes current beat this cycle

Behaviour:
- FSM states: IDLE, BURST, DONE. On reset: state = IDLE, beat = 0, owner = none, we_lat = 0, last_owner = I (so D wins the first tie). All outputs are 0.
- IDLE, arbitration on registered requests:
  - Only one requester pending: that requester wins.
  - Both pending: the requester that was not last_owner wins (alternating round-robin).
  - On a win: latch owner, we_lat (dc_we for D, 0 for I), base = addr with bits [$clog2(LINE_WORDS)+1:0] cleared, beat = 0; go to BURST next cycle.
  - No requests: stay in IDLE.
- BURST:
  - Outputs: mem_req = 1, mem_we = we_lat, mem_addr = base + (beat << 2), mem_wdata = dc_wdata (owner D, write), else 0. owner_grant = 1. dc_beat = beat (0 when D not owner).
  - Each cycle with mem_ready = 1, one beat completes. Read: owner_rvalid = 1 and owner_rdata = mem_rdata, combinational pass-through. Then beat increments.
  - mem_ready = 0: hold all outputs unchanged, no rvalid. No stall limit.
  - Completion of beat LINE_WORDS-1 → DONE, beat wraps to 0.
- DONE: one cycle. owner_done = 1, grant is still asserted, mem_req = 0. Set last_owner = owner, then IDLE.
- Latency:
  - Request sampled in IDLE at cycle N → BURST from N+1.
  - With mem_ready always high: beats N+1..N+LINE_WORDS, done at N+LINE_WORDS+1, IDLE at N+LINE_WORDS+2.
  - Earliest next grant is evaluated in that IDLE cycle.
- Deasserting req mid-burst is ignored; the burst always completes. A req still high in the cycle after done is treated as a new request.
- Non-owner outputs: grant, rvalid, done and rdata are all 0.
- ic_req while the D-cache owns the port is not lost; it wins the next tie.
- Reset mid-burst: the next edge returns to IDLE with all outputs 0. No done pulse; the partial transaction is discarded.
- Address arithmetic is modulo 2^32; the offset never carries out of the line because base is aligned.

Test Plan:
- I-cache refill: ic_req = 1, ic_addr = 0x0000_104C, mem_ready = 1, mem_rdata = 0xA0..0xA3 → mem_addr sequence 0x1040/44/48/4C, mem_we = 0, ic_rvalid ×4 carrying 0xA0..0xA3, ic_done pulse 5 cycles after grant.
- D-cache write-back: dc_req = 1, dc_we = 1, dc_addr = 0x2004, bench drives dc_wdata = 0x100 + dc_beat → mem_we = 1, mem_wdata 0x100..0x103 at 0x2000..0x200C, no dc_rvalid, single dc_done.
- Simultaneous: ic_req and dc_req both high from reset, both re-requesting → grant order D, I, D, I; each done pulse matches its owner.
- Memory stall: during a D refill, mem_ready low for 3 cycles after beat 1 → mem_addr and mem_req held at beat-2 address, no rvalid in those cycles, total burst length LINE_WORDS + 3 cycles.
- Reset mid-burst: rst_n low at beat 2 of an I refill → next cycle all outputs 0, state IDLE, no ic_done. After release with ic_req high, a fresh burst starts at beat 0.
- Req drop: dc_req deasserted after beat 0 → burst still runs 4 beats and dc_done pulses once. No new grant unless req is reasserted.
